// File: rtl/key_digit_capture.sv
// Enter-button front end: sync, debounce, sample switches, classify digit,
// and hold one result for the lock FSM behind a valid/ready buffer.
module key_digit_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [9:0] sw,
  output logic [3:0] digit,
  output logic       digit_err,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       press_dropped
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  logic          s1;
  logic          s2;
  deb_state_t    state;
  logic [CW-1:0] cnt;
  logic          press_ev;
  logic          sw_err;
  logic          take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      unique case (state)
        RELEASED: begin
          if (!s2) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (s2) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= PRESSED;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (s2) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (!s2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= RELEASED;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Only a debounced press fires an event; releases are silent.
  assign press_ev = (state == PRESS_WAIT) && !s2 && (cnt == CNT_MAX);
  assign sw_err   = sw > 10'd9;
  assign take     = press_ev && (!digit_valid || digit_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit         <= 4'd0;
      digit_err     <= 1'b0;
      digit_valid   <= 1'b0;
      press_dropped <= 1'b0;
    end else begin
      press_dropped <= press_ev && digit_valid && !digit_ready;
      if (take) begin
        digit_valid <= 1'b1;
        digit       <= sw_err ? 4'hF : sw[3:0];
        digit_err   <= sw_err;
      end else if (digit_valid && digit_ready) begin
        digit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_digit_capture.sv
// Bench for key_digit_capture: directed tables, edge-exact sequences,
// and random bouncing checked against a stability-run reference model.
module tb_key_digit_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic [9:0] sw = '0;
  logic       digit_ready = 1'b0;
  logic [3:0] digit;
  logic       digit_err;
  logic       digit_valid;
  logic       press_dropped;

  int passed = 0;
  int total = 0;
  int drops = 0;

  always #5 clk = ~clk;

  key_digit_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_n(key_n),
    .sw(sw),
    .digit(digit),
    .digit_err(digit_err),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .press_dropped(press_dropped)
  );

  // Model: debounced level flips once the synchronised input has shown
  // the opposite level on D+1 consecutive edges; a flip to 0 is a press.
  logic       m_s1, m_s2, m_deb;
  int         m_run;
  logic [3:0] m_digit;
  logic       m_err, m_valid, m_drop;

  always @(posedge clk or negedge rst_n) begin
    logic obs;
    logic ev;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_run = 0;
      m_digit = 4'd0; m_err = 1'b0; m_valid = 1'b0; m_drop = 1'b0;
    end else begin
      obs = m_s2;
      m_s2 = m_s1;
      m_s1 = key_n;
      ev = 1'b0;
      if (obs != m_deb) begin
        m_run++;
        if (m_run == D + 1) begin
          m_deb = obs;
          m_run = 0;
          ev = !obs;
        end
      end else begin
        m_run = 0;
      end
      m_drop = ev && m_valid && !digit_ready;
      if (ev && (!m_valid || digit_ready)) begin
        m_valid = 1'b1;
        m_err = (int'(sw) > 9);
        m_digit = m_err ? 4'hF : sw[3:0];
      end else if (m_valid && digit_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  always @(negedge clk) begin
    if (press_dropped) drops++;
    chk("model_valid", 32'(digit_valid), 32'(m_valid));
    chk("model_drop", 32'(press_dropped), 32'(m_drop));
    if (m_valid) begin
      chk("model_digit", 32'(digit), 32'(m_digit));
      chk("model_err", 32'(digit_err), 32'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press and hold until just after the event edge, then fully release.
  task automatic press(input logic [9:0] v);
    sw = v;
    key_n = 1'b0;
    step(D + 3);
  endtask

  task automatic release_key();
    key_n = 1'b1;
    step(D + 6);
  endtask

  typedef struct {
    logic [9:0] sw;
    logic [3:0] digit;
    logic       err;
  } vec_t;

  vec_t vt[$];

  initial begin
    int d0;
    vt = '{
      '{10'd6, 4'd6, 1'b0}, '{10'd3, 4'd3, 1'b0},
      '{10'd2, 4'd2, 1'b0}, '{10'd9, 4'd9, 1'b0},
      '{10'd1, 4'd1, 1'b0}, '{10'd4, 4'd4, 1'b0},
      '{10'd0, 4'd0, 1'b0}, '{10'd10, 4'hF, 1'b1},
      '{10'd12, 4'hF, 1'b1}, '{10'd16, 4'hF, 1'b1},
      '{10'd512, 4'hF, 1'b1}, '{10'd1023, 4'hF, 1'b1},
      '{10'd9, 4'd9, 1'b0}
    };

    step(2);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_err", 32'(digit_err), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_drop", 32'(press_dropped), 0);
    rst_n = 1'b1;
    step(2);

    // Exact press latency and single event while held.
    sw = 10'd6;
    digit_ready = 1'b1;
    key_n = 1'b0;
    step(6);
    chk("lat_before", 32'(digit_valid), 0);
    step(1);
    chk("lat_valid", 32'(digit_valid), 1);
    chk("lat_digit", 32'(digit), 6);
    chk("lat_err", 32'(digit_err), 0);
    step(1);
    chk("lat_consumed", 32'(digit_valid), 0);
    step(4);
    chk("held_no_repeat", 32'(digit_valid), 0);
    release_key();

    // Short press and fast bounce must never register.
    d0 = drops;
    key_n = 1'b0;
    step(3);
    key_n = 1'b1;
    step(2);
    for (int i = 0; i < 20; i++) begin
      key_n = ~key_n;
      step(1);
      chk("bounce_valid", 32'(digit_valid), 0);
    end
    key_n = 1'b1;
    step(D + 4);
    chk("bounce_drop", 32'(drops - d0), 0);

    // Table of digits and error codes.
    d0 = drops;
    foreach (vt[i]) begin
      press(vt[i].sw);
      chk("tbl_valid", 32'(digit_valid), 1);
      chk("tbl_digit", 32'(digit), 32'(vt[i].digit));
      chk("tbl_err", 32'(digit_err), 32'(vt[i].err));
      release_key();
      chk("tbl_hold_digit", 32'(digit), 32'(vt[i].digit));
    end
    chk("tbl_no_drop", 32'(drops - d0), 0);

    // Full buffer drops the second press.
    digit_ready = 1'b0;
    d0 = drops;
    press(10'd3);
    release_key();
    press(10'd2);
    chk("full_drop_pulse", 32'(press_dropped), 1);
    step(1);
    chk("full_drop_once", 32'(press_dropped), 0);
    chk("full_keep_digit", 32'(digit), 3);
    chk("full_keep_valid", 32'(digit_valid), 1);
    release_key();
    chk("full_drop_count", 32'(drops - d0), 1);
    digit_ready = 1'b1;
    step(1);
    digit_ready = 1'b0;
    chk("full_consumed", 32'(digit_valid), 0);
    chk("full_hold", 32'(digit), 3);

    // Reset during debounce, button held across release.
    digit_ready = 1'b1;
    sw = 10'd7;
    key_n = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_valid", 32'(digit_valid), 0);
    chk("mid_rst_digit", 32'(digit), 0);
    step(1);
    rst_n = 1'b1;
    step(6);
    chk("post_rst_before", 32'(digit_valid), 0);
    step(1);
    chk("post_rst_valid", 32'(digit_valid), 1);
    chk("post_rst_digit", 32'(digit), 7);
    release_key();

    // Random bouncing, switches and ready against the model.
    for (int i = 0; i < 400; i++) begin
      key_n = 1'($urandom_range(0, 1));
      sw = ($urandom_range(0, 3) == 0) ? 10'($urandom)
                                       : 10'($urandom_range(0, 15));
      for (int j = $urandom_range(1, 2 * D + 3); j > 0; j--) begin
        digit_ready = ($urandom_range(0, 2) != 0);
        step(1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
